// File: rtl/fma_wb_scheduler_pkg.sv
// Shared FMA writeback definitions: latency classes, pipeline latencies and the
// wrap-aware ROB age compare used for redirect flushing.
package fma_wb_scheduler_pkg;

    localparam int ADD_LAT    = 3;
    localparam int MUL_LAT    = 4;
    localparam int MADD_LAT   = 5;
    localparam int ROB_WIDTH  = 6;
    localparam int SLOT_DEPTH = MADD_LAT + 1;
    localparam int SLOT_IDX_W = $clog2(SLOT_DEPTH);

    typedef enum logic [1:0] {
        FMA_LAT_ADD,
        FMA_LAT_MUL,
        FMA_LAT_MADD
    } fma_lat_e;

    typedef logic [ROB_WIDTH-1:0] rob_idx_t;

    function automatic int lat_cycles(input fma_lat_e cls);
        case (cls)
            FMA_LAT_MUL:  return MUL_LAT;
            FMA_LAT_MADD: return MADD_LAT;
            default:      return ADD_LAT;
        endcase
    endfunction

    // Caller qualifies with $onehot; this only picks the class for a legal code.
    function automatic fma_lat_e type_class(input logic [2:0] req_type);
        if (req_type[2])      return FMA_LAT_MADD;
        else if (req_type[1]) return FMA_LAT_MUL;
        else                  return FMA_LAT_ADD;
    endfunction

    // Loop compare: the MSB is the wrap flag, the remaining bits the index.
    function automatic logic rob_is_older(input rob_idx_t a, input rob_idx_t b);
        if (a[ROB_WIDTH-1] == b[ROB_WIDTH-1])
            return a[ROB_WIDTH-2:0] < b[ROB_WIDTH-2:0];
        else
            return a[ROB_WIDTH-2:0] > b[ROB_WIDTH-2:0];
    endfunction

    function automatic logic rob_survives(input rob_idx_t slot, input rob_idx_t redirect_idx);
        return rob_is_older(slot, redirect_idx) || (slot == redirect_idx);
    endfunction

endpackage

// File: rtl/fma_wb_slot_row.sv
// One pipe's writeback reservation row: index i means "writes back i cycles from
// now". Shifts toward index 0 every cycle, applying the redirect flush on the way.
module fma_wb_slot_row
    import fma_wb_scheduler_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                set_valid,
    input  logic [SLOT_IDX_W-1:0]               set_idx,
    input  logic [ROB_WIDTH-1:0]                set_rob,
    input  logic [SLOT_DEPTH-1:1]               flush_mask,
    output logic [SLOT_DEPTH-1:0]               occ,
    output logic [SLOT_DEPTH-1:1][ROB_WIDTH-1:0] rob_tail,
    output logic                                wb_valid,
    output logic [ROB_WIDTH-1:0]                wb_rob
);

    logic [SLOT_DEPTH-1:0]                occ_q, occ_d;
    logic [SLOT_DEPTH-1:0][ROB_WIDTH-1:0] rob_q, rob_d;

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        occ_d = '0;
        rob_d = '0;
        for (int j = 0; j < SLOT_DEPTH - 1; j++) begin
            occ_d[j] = occ_q[j+1] & ~flush_mask[j+1];
            rob_d[j] = rob_q[j+1];
        end
        if (set_valid) begin
            occ_d[set_idx] = 1'b1;
            rob_d[set_idx] = set_rob;
        end
    end

    // NOTE: the rob payload array is reset too, so wb_rob reads zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
            rob_q <= '0;
        end else begin
            occ_q <= occ_d;
            rob_q <= rob_d;
        end
    end

    assign occ      = occ_q;
    assign rob_tail = rob_q[SLOT_DEPTH-1:1];
    assign wb_valid = occ_q[0];
    assign wb_rob   = rob_q[0];

endmodule

// File: rtl/fma_wb_scheduler.sv
// FMA writeback slot scheduler: grants issue requests only when their future
// writeback cycle has a free FP writeback port. Optional FMA_WB_STAT_EN adds deny counters.
module fma_wb_scheduler
    import fma_wb_scheduler_pkg::*;
#(
    parameter int UNIT_NUM = 2,
    parameter int WB_PORTS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [UNIT_NUM-1:0]           req_valid,
    input  logic [UNIT_NUM*3-1:0]         req_type,
    input  logic [UNIT_NUM*ROB_WIDTH-1:0] req_rob,
    output logic [UNIT_NUM-1:0]           grant,
    output logic [UNIT_NUM*3-1:0]         type_ready,
    input  logic                          redirect,
    input  logic [ROB_WIDTH-1:0]          redirect_idx,
`ifdef FMA_WB_STAT_EN
    output logic [UNIT_NUM*32-1:0]        stat_deny,
`endif
    output logic [UNIT_NUM-1:0]           wb_valid,
    output logic [UNIT_NUM*ROB_WIDTH-1:0] wb_rob
);

    localparam int PTR_W = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [UNIT_NUM-1:0][SLOT_DEPTH-1:0]                 row_occ;
    logic [UNIT_NUM-1:0][SLOT_DEPTH-1:1][ROB_WIDTH-1:0]  row_rob;
    logic [UNIT_NUM-1:0][SLOT_DEPTH-1:1]                 flush;
    logic [UNIT_NUM-1:0]                                 set_valid;
    logic [UNIT_NUM-1:0][SLOT_IDX_W-1:0]                 set_idx;
    logic [UNIT_NUM-1:0]                                 grant_c;
    logic [UNIT_NUM*3-1:0]                               ready_c;

    int       cnt   [SLOT_DEPTH];
    int       taken [SLOT_DEPTH];
    int       u, lat, last_u;
    logic     any_grant;
    logic [2:0]  typ;
    rob_idx_t    rob;

    always_comb begin
        grant_c   = '0;
        ready_c   = '0;
        set_valid = '0;
        set_idx   = '0;
        flush     = '0;
        any_grant = 1'b0;
        last_u    = 0;
        u         = 0;
        lat       = 0;
        typ       = '0;
        rob       = '0;
        for (int i = 0; i < SLOT_DEPTH; i++) begin
            cnt[i]   = 0;
            taken[i] = 0;
            for (int p = 0; p < UNIT_NUM; p++)
                cnt[i] = cnt[i] + int'(row_occ[p][i]);
        end

        for (int p = 0; p < UNIT_NUM; p++) begin
            for (int k = 0; k < 3; k++) begin
                lat = lat_cycles(fma_lat_e'(k));
                ready_c[p*3+k] = !row_occ[p][lat] && (cnt[lat] < WB_PORTS);
            end
            for (int j = 1; j < SLOT_DEPTH; j++)
                flush[p][j] = redirect && !rob_survives(row_rob[p][j], redirect_idx);
        end

        // Round-robin walk; earlier pipes in the walk consume slot capacity first.
        for (int k = 0; k < UNIT_NUM; k++) begin
            u   = (int'(rr_ptr_q) + k) % UNIT_NUM;
            typ = req_type[u*3 +: 3];
            rob = req_rob[u*ROB_WIDTH +: ROB_WIDTH];
            lat = lat_cycles(type_class(typ));
            if (req_valid[u] && $onehot(typ)
                && !(redirect && !rob_survives(rob, redirect_idx))
                && !row_occ[u][lat]
                && (cnt[lat] + taken[lat] < WB_PORTS)) begin
                grant_c[u]   = 1'b1;
                set_valid[u] = 1'b1;
                set_idx[u]   = SLOT_IDX_W'(lat - 1);
                taken[lat]   = taken[lat] + 1;
                last_u       = u;
                any_grant    = 1'b1;
            end
        end

        rr_ptr_d = any_grant ? PTR_W'((last_u + 1) % UNIT_NUM) : rr_ptr_q;
    end

    assign grant      = rst ? grant_c : '0;
    assign type_ready = rst ? ready_c : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr_q <= '0;
        else      rr_ptr_q <= rr_ptr_d;
    end

    for (genvar g = 0; g < UNIT_NUM; g++) begin : g_row
        fma_wb_slot_row u_row (
            .clk        (clk),
            .rst        (rst),
            .set_valid  (set_valid[g]),
            .set_idx    (set_idx[g]),
            .set_rob    (req_rob[g*ROB_WIDTH +: ROB_WIDTH]),
            .flush_mask (flush[g]),
            .occ        (row_occ[g]),
            .rob_tail   (row_rob[g]),
            .wb_valid   (wb_valid[g]),
            .wb_rob     (wb_rob[g*ROB_WIDTH +: ROB_WIDTH])
        );
    end

`ifdef FMA_WB_STAT_EN
    logic [UNIT_NUM-1:0][31:0] deny_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deny_q <= '0;
        end else begin
            for (int p = 0; p < UNIT_NUM; p++)
                if (req_valid[p] && !grant[p] && (deny_q[p] != '1))
                    deny_q[p] <= deny_q[p] + 32'd1;
        end
    end

    assign stat_deny = deny_q;
`endif

endmodule
